// File: rtl/hex_display_scanner_if.sv
// hex_display_scanner_if
//   Bundles the value/control inputs and the display outputs of the hex
//   display scanner so a register tap and the display driver connect as one.
//   master : drives load, value_in, dig_en, blank_lz, blink_en;
//            observes seg_all, seg_scan, digit_sel, frame.
//   slave  : the display driver side (directions reversed).
interface hex_display_scanner_if #(
   parameter int DIGITS = 4
);
   logic                  load;
   logic [4*DIGITS-1:0]   value_in;
   logic [DIGITS-1:0]     dig_en;
   logic                  blank_lz;
   logic                  blink_en;
   logic [7*DIGITS-1:0]   seg_all;
   logic [6:0]            seg_scan;
   logic [DIGITS-1:0]     digit_sel;
   logic                  frame;

   modport master (
      output load, value_in, dig_en, blank_lz, blink_en,
      input  seg_all, seg_scan, digit_sel, frame
   );

   modport slave (
      input  load, value_in, dig_en, blank_lz, blink_en,
      output seg_all, seg_scan, digit_sel, frame
   );
endinterface

// File: rtl/hex_display_scanner.sv
// hex_display_scanner
//   Multi-digit hex 7-segment driver. Latches a DIGITS x 4-bit value on load,
//   presents every digit on a static segment bus (seg_all) and also scans the
//   digits one at a time (seg_scan + digit_sel). Supports leading-zero
//   blanking, a per-digit enable mask and whole-display blinking.
//   Ports:
//     clock  - system clock, rising edge
//     reset  - synchronous, active-high
//     bus    - hex_display_scanner_if.slave
//              in : load, value_in, dig_en, blank_lz, blink_en
//              out: seg_all, seg_scan, digit_sel, frame (all registered)
//   Segment bit order is a..g on bits 0..6. With ACTIVE_LOW=1 a 0 lights a
//   segment / selects a digit; ACTIVE_LOW=0 inverts every output bit.
module hex_display_scanner #(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int BLINK_SCANS = 25,
   parameter int ACTIVE_LOW  = 1
) (
   input logic                  clock,
   input logic                  reset,
   hex_display_scanner_if.slave bus
);
   localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1)      ? $clog2(DIGITS)      : 1;
   localparam int BLK_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

   localparam logic [6:0]        BLANK_OUT = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic [DIGITS-1:0] SEL_NONE  = (ACTIVE_LOW != 0) ? '1 : '0;

   // Glyph table in active-low form (0 = segment lit).
   function automatic logic [6:0] glyph_low(input logic [3:0] v);
      logic [6:0] g;
      case (v)
         4'h0:    g = 7'b1000000;
         4'h1:    g = 7'b1111001;
         4'h2:    g = 7'b0100100;
         4'h3:    g = 7'b0110000;
         4'h4:    g = 7'b0011001;
         4'h5:    g = 7'b0010010;
         4'h6:    g = 7'b0000010;
         4'h7:    g = 7'b1111000;
         4'h8:    g = 7'b0000000;
         4'h9:    g = 7'b0011000;
         4'hA:    g = 7'b0001000;
         4'hB:    g = 7'b0000011;
         4'hC:    g = 7'b1000110;
         4'hD:    g = 7'b0100001;
         4'hE:    g = 7'b0000110;
         default: g = 7'b0001110;
      endcase
      return g;
   endfunction

   logic [4*DIGITS-1:0] value_reg;
   logic [DIV_W-1:0]    div_reg;
   logic [IDX_W-1:0]    idx_reg;
   logic                wrapped_reg;
   logic                frame_reg;
   logic [BLK_W-1:0]    blink_cnt_reg;
   logic                blink_off_reg;
   logic [7*DIGITS-1:0] seg_all_reg;
   logic [6:0]          seg_scan_reg;
   logic [DIGITS-1:0]   digit_sel_reg;

   logic                div_tc;
   logic                wrap;
   logic [DIGITS-1:0]   upper_zero;
   logic [DIGITS-1:0]   digit_blank;
   logic [DIGITS-1:0]   sel_hit;
   logic [6:0]          glyph_out [DIGITS];
   logic [7*DIGITS-1:0] seg_all_next;
   logic [6:0]          seg_scan_next;
   logic [DIGITS-1:0]   digit_sel_next;

   assign div_tc = (div_reg == DIV_W'(REFRESH_DIV - 1));
   assign wrap   = div_tc && (idx_reg == IDX_W'(DIGITS - 1));

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         // Nibbles gi..DIGITS-1 all zero: this digit is a leading zero.
         assign upper_zero[gi]  = (value_reg[4*DIGITS-1:4*gi] == '0);
         assign digit_blank[gi] = !bus.dig_en[gi] || blink_off_reg ||
                                  (bus.blank_lz && (gi != 0) && upper_zero[gi]);
         assign glyph_out[gi]   = digit_blank[gi] ? BLANK_OUT :
                                  ((ACTIVE_LOW != 0) ? glyph_low(value_reg[4*gi +: 4])
                                                     : ~glyph_low(value_reg[4*gi +: 4]));
         assign seg_all_next[7*gi +: 7] = glyph_out[gi];
         assign sel_hit[gi]     = (idx_reg == IDX_W'(gi));
      end
   endgenerate

   assign digit_sel_next = (ACTIVE_LOW != 0) ? ~sel_hit : sel_hit;

   // Explicit compare mux so a non-power-of-two DIGITS never indexes past the array.
   always_comb begin
      seg_scan_next = glyph_out[0];
      for (int i = 1; i < DIGITS; i++) begin
         if (idx_reg == IDX_W'(i)) seg_scan_next = glyph_out[i];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         value_reg     <= '0;
         div_reg       <= '0;
         idx_reg       <= '0;
         wrapped_reg   <= 1'b0;
         frame_reg     <= 1'b0;
         blink_cnt_reg <= '0;
         blink_off_reg <= 1'b0;
         seg_all_reg   <= {DIGITS{BLANK_OUT}};
         seg_scan_reg  <= BLANK_OUT;
         digit_sel_reg <= SEL_NONE;
      end else begin
         if (bus.load) value_reg <= bus.value_in;

         if (div_tc) begin
            div_reg <= '0;
            idx_reg <= (idx_reg == IDX_W'(DIGITS - 1)) ? '0 : idx_reg + 1'b1;
         end else begin
            div_reg <= div_reg + 1'b1;
         end

         // wrapped_reg lines the wrap up with the digit_sel pipeline stage,
         // so frame is high exactly while digit 0 is first shown.
         wrapped_reg <= wrap;
         frame_reg   <= wrapped_reg;

         if (!bus.blink_en) begin
            blink_cnt_reg <= '0;
            blink_off_reg <= 1'b0;
         end else if (wrap) begin
            if (blink_cnt_reg == BLK_W'(BLINK_SCANS - 1)) begin
               blink_cnt_reg <= '0;
               blink_off_reg <= ~blink_off_reg;
            end else begin
               blink_cnt_reg <= blink_cnt_reg + 1'b1;
            end
         end

         seg_all_reg   <= seg_all_next;
         seg_scan_reg  <= seg_scan_next;
         digit_sel_reg <= digit_sel_next;
      end
   end

   assign bus.seg_all   = seg_all_reg;
   assign bus.seg_scan  = seg_scan_reg;
   assign bus.digit_sel = digit_sel_reg;
   assign bus.frame     = frame_reg;
endmodule

// File: tb/tb_hex_display_scanner.sv
// tb_hex_display_scanner
//   Self-checking bench for hex_display_scanner (DIGITS=4, REFRESH_DIV=4,
//   BLINK_SCANS=2, ACTIVE_LOW=1). A reference model derives every expected
//   output from the number of edges since reset, the loaded value and the
//   count of scan frames seen while blinking is enabled.
module tb_hex_display_scanner;
   localparam int D = 4;
   localparam int R = 4;
   localparam int B = 2;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   hex_display_scanner_if #(.DIGITS(D)) bus ();

   hex_display_scanner #(
      .DIGITS(D), .REFRESH_DIV(R), .BLINK_SCANS(B), .ACTIVE_LOW(1)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state: edges since reset, latched value, frames since blink on.
   logic [15:0] m_val = '0;
   int          m_n   = 0;
   int          m_w   = 0;
   logic [27:0] e_seg_all;
   logic [6:0]  e_seg_scan;
   logic [3:0]  e_sel;
   logic        e_frame;

   localparam logic [6:0] BL = 7'b1111111;

   function automatic logic [6:0] glyph(input logic [3:0] v);
      logic [6:0] t [16];
      t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
      return t[v];
   endfunction

   // Advance one edge; compute what the outputs must be after it, then update the model.
   task automatic step();
      int idx;
      @(posedge clock);
      #1;
      if (reset) begin
         e_seg_all  = {4{BL}};
         e_seg_scan = BL;
         e_sel      = 4'b1111;
         e_frame    = 1'b0;
         m_val = '0; m_n = 0; m_w = 0;
      end else begin
         for (int i = 0; i < D; i++) begin
            logic blank;
            blank = !bus.dig_en[i] || (((m_w / B) % 2) == 1) ||
                    (bus.blank_lz && i != 0 && (m_val >> (4 * i)) == 16'd0);
            e_seg_all[7*i +: 7] = blank ? BL : glyph(m_val[4*i +: 4]);
         end
         idx        = (m_n / R) % D;
         e_sel      = ~(4'b0001 << idx);
         e_seg_scan = e_seg_all[7*idx +: 7];
         e_frame    = (m_n > 0) && (m_n % (R * D) == 0);
         m_n++;
         if (!bus.blink_en) m_w = 0;
         else if (m_n % (R * D) == 0) m_w++;
         if (bus.load) m_val = bus.value_in;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; bus.load = 1'b0; bus.value_in = '0; bus.dig_en = '0;
      bus.blank_lz = 1'b0; bus.blink_en = 1'b0;
      step(); step();
      checks++;
      if (bus.seg_all !== {4{BL}}) begin errors++; $display("FAIL reset_seg_all got %h want %h", bus.seg_all, {4{BL}}); end
      checks++;
      if (bus.seg_scan !== BL) begin errors++; $display("FAIL reset_seg_scan got %b want %b", bus.seg_scan, BL); end
      checks++;
      if (bus.digit_sel !== 4'b1111) begin errors++; $display("FAIL reset_sel got %b want 1111", bus.digit_sel); end
      checks++;
      if (bus.frame !== 1'b0) begin errors++; $display("FAIL reset_frame got %b want 0", bus.frame); end
      reset = 1'b0;
   endtask

   task automatic test_load_glyphs();
      logic [27:0] want;
      want = {7'b1111001, 7'b0001000, 7'b0110000, 7'b0001110};
      bus.dig_en = 4'hF; bus.blank_lz = 1'b0;
      bus.load = 1'b1; bus.value_in = 16'h1A3F;
      step();
      bus.load = 1'b0;
      checks++;
      if (bus.seg_all !== e_seg_all) begin errors++; $display("FAIL load_latency got %h want %h", bus.seg_all, e_seg_all); end
      step();
      checks++;
      if (bus.seg_all !== want) begin errors++; $display("FAIL load_1A3F got %h want %h", bus.seg_all, want); end
   endtask

   task automatic test_lz();
      logic [27:0] w1, w2;
      w1 = {BL, BL, 7'b1111000, 7'b1000000};
      w2 = {BL, BL, BL, 7'b1000000};
      bus.blank_lz = 1'b1; bus.load = 1'b1; bus.value_in = 16'h0070;
      step(); bus.load = 1'b0; step();
      checks++;
      if (bus.seg_all !== w1) begin errors++; $display("FAIL lz_0070 got %h want %h", bus.seg_all, w1); end
      bus.load = 1'b1; bus.value_in = 16'h0000;
      step(); bus.load = 1'b0; step();
      checks++;
      if (bus.seg_all !== w2) begin errors++; $display("FAIL lz_0000 got %h want %h", bus.seg_all, w2); end
      bus.dig_en = 4'b1110;
      step(); step();
      checks++;
      if (bus.seg_all !== {4{BL}}) begin errors++; $display("FAIL lz_dig_en got %h want %h", bus.seg_all, {4{BL}}); end
      bus.dig_en = 4'hF; bus.blank_lz = 1'b0;
   endtask

   task automatic test_scan();
      int frames = 0;
      bus.load = 1'b1; bus.value_in = 16'h1A3F;
      step(); bus.load = 1'b0; step();
      for (int c = 0; c < 48; c++) begin
         step();
         if (bus.frame === 1'b1) frames++;
         checks++;
         if (bus.digit_sel !== e_sel || bus.seg_scan !== e_seg_scan || bus.frame !== e_frame) begin
            errors++;
            $display("FAIL scan c=%0d got sel=%b seg=%b fr=%b want sel=%b seg=%b fr=%b",
                     c, bus.digit_sel, bus.seg_scan, bus.frame, e_sel, e_seg_scan, e_frame);
         end
         if (bus.digit_sel === 4'b1110) begin
            checks++;
            if (bus.seg_scan !== 7'b0001110) begin errors++; $display("FAIL scan_digit0 got %b want 0001110", bus.seg_scan); end
         end
      end
      checks++;
      if (frames != 3) begin errors++; $display("FAIL scan_frames got %0d want 3", frames); end
   endtask

   task automatic test_blink();
      int  run = 0;
      int  runs = 0;
      logic prev_blank = 1'b0;
      logic cur_blank;
      bus.blink_en = 1'b1;
      for (int c = 0; c < 180; c++) begin
         step();
         checks++;
         if (bus.seg_all !== e_seg_all || bus.digit_sel !== e_sel || bus.seg_scan !== e_seg_scan) begin
            errors++;
            $display("FAIL blink c=%0d got seg=%h sel=%b want seg=%h sel=%b",
                     c, bus.seg_all, bus.digit_sel, e_seg_all, e_sel);
         end
         cur_blank = (bus.seg_all === {4{BL}});
         if (c > 0 && cur_blank != prev_blank) begin
            // First visible run includes the partial frame before the first wrap.
            if (runs > 0) begin
               checks++;
               if (run != 2 * R * D) begin errors++; $display("FAIL blink_half got %0d want %0d", run, 2 * R * D); end
            end
            runs++;
            run = 0;
         end
         run++;
         prev_blank = cur_blank;
      end
      // Continue until the model is in the blank phase, then drop blink_en.
      for (int c = 0; c < 80 && ((m_w / B) % 2) == 0; c++) step();
      bus.blink_en = 1'b0;
      step(); step();
      checks++;
      if (bus.seg_all !== {7'b1111001, 7'b0001000, 7'b0110000, 7'b0001110}) begin
         errors++; $display("FAIL blink_off got %h want visible 1A3F", bus.seg_all);
      end
   endtask

   task automatic test_mid_reset();
      logic found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         step();
         if (bus.digit_sel === 4'b1011) found = 1'b1;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL mid_reset_wait got timeout want sel 1011"); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if (bus.seg_all !== {4{BL}} || bus.seg_scan !== BL || bus.digit_sel !== 4'b1111 || bus.frame !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset got seg=%h scan=%b sel=%b fr=%b want blank/blank/1111/0",
                  bus.seg_all, bus.seg_scan, bus.digit_sel, bus.frame);
      end
      for (int c = 0; c < 4; c++) begin
         step();
         checks++;
         if (bus.digit_sel !== 4'b1110) begin errors++; $display("FAIL mid_reset_hold c=%0d got %b want 1110", c, bus.digit_sel); end
      end
      checks++;
      if (bus.seg_all !== {4{7'b1000000}}) begin errors++; $display("FAIL mid_reset_value got %h want %h", bus.seg_all, {4{7'b1000000}}); end
      step();
      checks++;
      if (bus.digit_sel !== 4'b1101) begin errors++; $display("FAIL mid_reset_next got %b want 1101", bus.digit_sel); end
   endtask

   task automatic test_load_reset();
      logic saw_f = 1'b0;
      reset = 1'b1; bus.load = 1'b1; bus.value_in = 16'hFFFF;
      step();
      reset = 1'b0; bus.load = 1'b0;
      for (int c = 0; c < 24; c++) begin
         step();
         for (int i = 0; i < D; i++) if (bus.seg_all[7*i +: 7] === 7'b0001110) saw_f = 1'b1;
         if (bus.seg_scan === 7'b0001110) saw_f = 1'b1;
         checks++;
         if (bus.seg_all !== e_seg_all) begin errors++; $display("FAIL load_reset c=%0d got %h want %h", c, bus.seg_all, e_seg_all); end
      end
      checks++;
      if (saw_f) begin errors++; $display("FAIL load_reset_f got F glyph want none"); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         reset        = ($urandom_range(0, 199) == 0);
         bus.load     = ($urandom_range(0, 7) == 0);
         bus.value_in = 16'($urandom);
         if ($urandom_range(0, 15) == 0) bus.dig_en = 4'($urandom);
         if ($urandom_range(0, 15) == 0) bus.blank_lz = 1'($urandom);
         if ($urandom_range(0, 59) == 0) bus.blink_en = ~bus.blink_en;
         step();
         checks++;
         if (bus.seg_all !== e_seg_all || bus.seg_scan !== e_seg_scan ||
             bus.digit_sel !== e_sel || bus.frame !== e_frame) begin
            errors++;
            $display("FAIL random c=%0d got seg=%h scan=%b sel=%b fr=%b want seg=%h scan=%b sel=%b fr=%b",
                     c, bus.seg_all, bus.seg_scan, bus.digit_sel, bus.frame,
                     e_seg_all, e_seg_scan, e_sel, e_frame);
         end
      end
      reset = 1'b0; bus.load = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load_glyphs();
      test_lz();
      test_scan();
      test_blink();
      test_mid_reset();
      test_load_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
- Parametrised multi-digit hex display driver that replaces per-digit combinational decoders.
- Latches a DIGITS×4-bit value on a load strobe.
- Drives static per-digit segment buses and a time-multiplexed scan interface (one segment bus plus digit select).
- Adds leading-zero blanking, a per-digit enable mask and blink mode. Sits between processor debug/register taps and board 7-segment displays.

Parameters:
DIGITS, 4, number of hex digits (1..8)
REFRESH_DIV, 50000, clock cycles each digit is held in scan mode (>=1)
BLINK_SCANS, 25, complete scan frames per blink half-period (>=1)
ACTIVE_LOW, 1, 1: segment/select bit 0 = lit/selected; 0: polarity inverted

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
load  input  1  capture value_in this cycle
value_in  input  4*DIGITS  nibble i = digit i (digit 0 = least significant)
dig_en  input  DIGITS  per-digit enable; 0 forces blank
blank_lz  input  1  enable leading-zero blanking
blink_en  input  1  enable blinking of all digits
seg_all  output  7*DIGITS  static glyphs, bits [7i+6:7i] = digit i
seg_scan  output  7  glyph of currently scanned digit
digit_sel  output  DIGITS  one-hot (one-cold if ACTIVE_LOW) scan select
frame  output  1  one-cycle pulse when scan wraps from DIGITS-1 to 0

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Segment bit order: bit0=a … bit6=g. Glyphs, ACTIVE_LOW=1 form (g..a): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110, blank=1111111. ACTIVE_LOW=0 inverts every segment and select bit.
- Reset (priority over all inputs, including a simultaneous load):
  - value register cleared to 0; div counter and scan index cleared to 0.
  - blink counter cleared; blink phase = visible.
  - seg_all and seg_scan = blank; digit_sel = none selected (all 1 if ACTIVE_LOW); frame = 0.
- Load: on an edge with load=1, value register <= value_in. All outputs are registered. seg_all shows the new value on the 2nd rising edge after load is sampled (2-cycle latency). Back-to-back loads: the last one wins.
- Digit i is blank if any of these holds:
  - dig_en[i]=0;
  - blink phase is off;
  - blank_lz=1, i!=0, and nibbles i..DIGITS-1 are all zero. Digit 0 is never LZ-blanked, so value 0 shows a single "0".
- Scan:
  - div counter counts 0..REFRESH_DIV-1. At terminal count it returns to 0 and scan index advances. Scan index wraps DIGITS-1 -> 0.
  - digit_sel and seg_scan are registered from scan index and the digit glyph; same pipeline as seg_all, so they are always mutually consistent.
  - frame pulses for one cycle on the cycle digit_sel first selects digit 0 after a wrap.
  - REFRESH_DIV=1: advance every cycle. DIGITS=1: digit_sel constantly selected; frame pulses every REFRESH_DIV cycles.
  - Scanning is never stalled or reset by load.
- Blink:
  - When blink_en=1, blink counter counts frame pulses. After BLINK_SCANS frames the phase toggles and the counter returns to 0.
  - While blink_en=0, phase is forced visible and the counter is held at 0, so the first blink half-period is always visible.
  - The blank phase blanks segments only; digit_sel keeps scanning.
- Widths: div counter = max(1, clog2(REFRESH_DIV)); scan index = max(1, clog2(DIGITS)); blink counter = max(1, clog2(BLINK_SCANS)).
- Mid-operation reset: outputs blank next edge; scan restarts at digit 0 with a full REFRESH_DIV hold.

Test Plan:
- Config for all cases: DIGITS=4, REFRESH_DIV=4, BLINK_SCANS=2, ACTIVE_LOW=1.
- Reset, then load 16'h1A3F with dig_en=4'hF and blank_lz=0 -> 2 edges later seg_all digit0..3 = 0001110, 0110000, 0001000, 1111001.
- Load 16'h0070 with blank_lz=1 -> digits 3,2 = 1111111, digit1 = 1111000, digit0 = 1000000. Then load 16'h0000 -> only digit0 = 1000000. Then dig_en=4'b1110 -> digit0 blank.
- Free-run with 16'h1A3F loaded -> digit_sel 1110, 1101, 1011, 0111, each held exactly 4 cycles. seg_scan matches the digit (0001110 with 1110, etc.). frame pulses every 16 cycles, coincident with 1110.
- Raise blink_en -> segments visible for 2 frames (32 cycles), blank for 32 cycles, repeating while digit_sel keeps scanning. Drop blink_en while blank -> visible on the next registered update.
- Assert reset while digit_sel=1011 -> next edge seg_all/seg_scan blank, digit_sel=1111, frame=0. After release, 1110 is held 4 cycles and the value reads 0.
- Assert load=1 (value_in=16'hFFFF) and reset together -> value stays 0; no F glyph ever appears.
